// File: rtl/alu_pkg.sv
// Shared arithmetic-unit definitions: divider widths, state encoding and sign helpers.
// Pure declarations; no latency or backpressure of its own.
package alu_pkg;

    localparam int DIV_WIDTH = 8;
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } div_state_t;

    function automatic logic [DIV_WIDTH-1:0] twos_neg(input logic [DIV_WIDTH-1:0] a);
        return ~a + DIV_WIDTH'(1);
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Divider request/result bundle: start/busy/done handshake plus operands and results.
// Master launches operations; slave (the divider) returns results with a done pulse.
interface seq_divider_if #(
    parameter int WIDTH = alu_pkg::DIV_WIDTH
);
    logic             start;
    logic             signed_op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output start, signed_op, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero, overflow
    );

    modport slave (
        input  start, signed_op, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero, overflow
    );
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step on {R,Q} against divisor D.
// Zero latency; no flow control.
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   r,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   r_next,
    output logic [WIDTH-1:0] q_next
);
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;

    always_comb begin
        shifted = {r, q[WIDTH-1]};
        trial   = shifted - {2'b00, d};
        if (!trial[WIDTH+1]) begin
            r_next = trial[WIDTH:0];
            q_next = {q[WIDTH-2:0], 1'b1};
        end else begin
            r_next = shifted[WIDTH:0];
            q_next = {q[WIDTH-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/seq_divider.sv
// Sequential signed/unsigned restoring divider; done WIDTH+1 edges after accept (1 for divide-by-zero).
// start is ignored while busy; results hold until the next operation completes.
module seq_divider
    import alu_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    seq_divider_if.slave div
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       state;
    div_state_t       state_nxt;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   r_reg;
    logic [WIDTH:0]   r_nxt;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH-1:0] dvd_raw;
    logic             sign_q;
    logic             sign_r;
    logic             zero_flag;
    logic             ovf_flag;

    logic [WIDTH-1:0] quot_reg;
    logic [WIDTH-1:0] rem_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             dz_reg;
    logic             ovf_reg;

    logic             neg_a;
    logic             neg_b;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    div_step #(.WIDTH(WIDTH)) u_step (
        .r      (r_reg),
        .q      (q_reg),
        .d      (d_reg),
        .r_next (r_nxt),
        .q_next (q_nxt)
    );

    always_comb begin
        neg_a = div.signed_op & div.dividend[WIDTH-1];
        neg_b = div.signed_op & div.divisor[WIDTH-1];
        abs_a = neg_a ? twos_neg(div.dividend) : div.dividend;
        abs_b = neg_b ? twos_neg(div.divisor) : div.divisor;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (div.start)
                    state_nxt = (div.divisor == '0) ? ST_FIX : ST_CALC;
            end
            ST_CALC: begin
                if (count == CW'(1))
                    state_nxt = ST_FIX;
            end
            ST_FIX:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            count     <= '0;
            r_reg     <= '0;
            q_reg     <= '0;
            d_reg     <= '0;
            dvd_raw   <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            zero_flag <= 1'b0;
            ovf_flag  <= 1'b0;
            quot_reg  <= '0;
            rem_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            dz_reg    <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            state    <= state_nxt;
            done_reg <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (div.start) begin
                        busy_reg  <= 1'b1;
                        dvd_raw   <= div.dividend;
                        zero_flag <= (div.divisor == '0);
                        ovf_flag  <= div.signed_op && (div.dividend == MIN_NEG) && (div.divisor == '1);
                        r_reg     <= '0;
                        q_reg     <= abs_a;
                        d_reg     <= abs_b;
                        sign_q    <= neg_a ^ neg_b;
                        sign_r    <= neg_a;
                        count     <= CW'(WIDTH);
                    end
                end
                ST_CALC: begin
                    r_reg <= r_nxt;
                    q_reg <= q_nxt;
                    count <= count - CW'(1);
                end
                ST_FIX: begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b1;
                    if (zero_flag) begin
                        quot_reg <= DIV_ZERO_QUOT;
                        rem_reg  <= dvd_raw;
                        dz_reg   <= 1'b1;
                        ovf_reg  <= 1'b0;
                    end else if (ovf_flag) begin
                        // -MIN / -1 cannot be represented; it wraps back to MIN.
                        quot_reg <= MIN_NEG;
                        rem_reg  <= '0;
                        dz_reg   <= 1'b0;
                        ovf_reg  <= 1'b1;
                    end else begin
                        quot_reg <= sign_q ? twos_neg(q_reg) : q_reg;
                        rem_reg  <= sign_r ? twos_neg(r_reg[WIDTH-1:0]) : r_reg[WIDTH-1:0];
                        dz_reg   <= 1'b0;
                        ovf_reg  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign div.quotient    = quot_reg;
    assign div.remainder   = rem_reg;
    assign div.busy        = busy_reg;
    assign div.done        = done_reg;
    assign div.div_by_zero = dz_reg;
    assign div.overflow    = ovf_reg;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: an arithmetic reference model feeds a result queue
// that is drained and compared each time done pulses.
module tb_seq_divider;

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        logic       ov;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   edge_cnt = 0;
    int   start_edge = 0;
    res_t sb[$];

    seq_divider_if dif();

    seq_divider dut (
        .clk (clk),
        .rst (rst),
        .div (dif)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic res_t model(input logic [7:0] a, input logic [7:0] b, input logic s);
        res_t m;
        int ia, ib, iq, ir;
        m = '0;
        if (b == 8'h00) begin
            m.q  = 8'hFF;
            m.r  = a;
            m.dz = 1'b1;
        end else if (s) begin
            ia = $signed(a);
            ib = $signed(b);
            if (ia == -128 && ib == -1) begin
                m.q  = 8'h80;
                m.r  = 8'h00;
                m.ov = 1'b1;
            end else begin
                iq   = ia / ib;
                ir   = ia % ib;
                m.q  = iq[7:0];
                m.r  = ir[7:0];
            end
        end else begin
            m.q = a / b;
            m.r = a % b;
        end
        return m;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_quot"}, 32'(dif.quotient), 32'h0);
        check({tag, "_rem"},  32'(dif.remainder), 32'h0);
        check({tag, "_busy"}, 32'(dif.busy), 32'h0);
        check({tag, "_done"}, 32'(dif.done), 32'h0);
        check({tag, "_dz"},   32'(dif.div_by_zero), 32'h0);
        check({tag, "_ovf"},  32'(dif.overflow), 32'h0);
    endtask

    task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic s);
        dif.start     = 1'b1;
        dif.dividend  = a;
        dif.divisor   = b;
        dif.signed_op = s;
        sb.push_back(model(a, b, s));
        start_edge = edge_cnt + 1;
        @(negedge clk);
        dif.start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_lat, input int exp_busy);
        int   busy_cnt;
        bit   seen;
        res_t e;
        busy_cnt = 0;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (dif.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (dif.busy === 1'b1) busy_cnt++;
            @(negedge clk);
        end
        check({tag, "_done_seen"}, 32'(seen), 32'h1);
        check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'h1);
        if (sb.size() > 0) e = sb.pop_front();
        else e = '0;
        if (seen) begin
            check({tag, "_latency"}, 32'(edge_cnt - start_edge), 32'(exp_lat));
            if (exp_busy >= 0) check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
            check({tag, "_busy_at_done"}, 32'(dif.busy), 32'h0);
            check({tag, "_quot"}, 32'(dif.quotient), 32'(e.q));
            check({tag, "_rem"},  32'(dif.remainder), 32'(e.r));
            check({tag, "_dz"},   32'(dif.div_by_zero), 32'(e.dz));
            check({tag, "_ovf"},  32'(dif.overflow), 32'(e.ov));
        end
    endtask

    initial begin
        int done_hits;
        res_t dropped;
        dif.start     = 1'b0;
        dif.signed_op = 1'b0;
        dif.dividend  = 8'h00;
        dif.divisor   = 8'h00;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_outputs_zero("reset");

        // unsigned 100/7 with latency, busy width and pulse width
        launch(8'd100, 8'd7, 1'b0);
        wait_done("u100_7", 9, 9);
        @(negedge clk);
        check("u100_7_done_pulse", 32'(dif.done), 32'h0);
        check("u100_7_hold_quot", 32'(dif.quotient), 32'h0E);

        launch(8'h9C, 8'h07, 1'b1);
        wait_done("s_m100_7", 9, 9);
        launch(8'd100, 8'hF9, 1'b1);
        wait_done("s_100_m7", 9, 9);

        launch(8'h80, 8'hFF, 1'b1);
        wait_done("s_ovf", 9, 9);
        launch(8'h80, 8'hFF, 1'b0);
        wait_done("u_80_ff", 9, 9);

        launch(8'h37, 8'h00, 1'b0);
        wait_done("u_dz", 1, 1);
        launch(8'h37, 8'h00, 1'b1);
        wait_done("s_dz", 1, 1);

        // start during CALC is ignored; start in the done cycle is accepted
        launch(8'd100, 8'd7, 1'b0);
        repeat (2) @(negedge clk);
        dif.start    = 1'b1;
        dif.dividend = 8'd200;
        dif.divisor  = 8'd3;
        @(negedge clk);
        dif.start = 1'b0;
        wait_done("ignored_start", 9, -1);
        launch(8'd200, 8'd3, 1'b0);
        wait_done("b2b_200_3", 9, 9);

        // reset during the fourth CALC step
        launch(8'd100, 8'd7, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        if (sb.size() > 0) dropped = sb.pop_back();
        check_outputs_zero("mid_reset");
        done_hits = 0;
        for (int k = 0; k < 12; k++) begin
            if (dif.done === 1'b1) done_hits++;
            @(negedge clk);
        end
        check("mid_reset_no_done", 32'(done_hits), 32'h0);
        launch(8'd9, 8'd3, 1'b0);
        wait_done("after_reset_9_3", 9, 9);

        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle restoring divider for the arithmetic unit; it is the inverse operation to the multiplier.
- Divides an 8-bit dividend by an 8-bit divisor, signed or unsigned, and produces quotient and remainder.
- Uses a start/busy/done handshake. The ALU result mux samples the outputs when done pulses.

Parameters:
- WIDTH, 8, operand, quotient and remainder width in bits.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a division; sampled only in IDLE.
- signed_op  in  1  1 = two's-complement operands, 0 = unsigned; latched with start.
- dividend  in  WIDTH  numerator; latched on accepted start.
- divisor  in  WIDTH  denominator; latched on accepted start.
- quotient  out  WIDTH  result, truncated toward zero.
- remainder  out  WIDTH  result; takes the sign of the dividend when signed_op=1.
- busy  out  1  high from the accepted start until the result is written.
- done  out  1  one-cycle pulse; results are valid from this cycle onward.
- div_by_zero  out  1  divisor was 0 for the last operation.
- overflow  out  1  signed -2^(WIDTH-1) / -1 for the last operation.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset: state=IDLE. quotient, remainder, busy, done, div_by_zero and overflow all become 0. Reset mid-operation aborts immediately and no done is produced.
- States: IDLE, CALC, FIX.
- IDLE, start=1, divisor!=0:
  - Latch |dividend| and |divisor|; absolute value only when signed_op=1.
  - Latch sign_q = sign(dividend) XOR sign(divisor), and sign_r = sign(dividend).
  - Clear the partial remainder R (WIDTH+1 bits) and set count=WIDTH; go to CALC; busy=1.
- IDLE, start=1, divisor==0:
  - Go to FIX with the zero flag set.
  - FIX then writes quotient = all ones, remainder = dividend (unmodified), div_by_zero=1, overflow=0.
- CALC, one step per cycle:
  - Shift {R,Q} left by 1.
  - Compute trial = R - D.
  - If trial is non-negative (MSB 0): R=trial and Q[0]=1. Otherwise R is unchanged and Q[0]=0.
  - Decrement count; after WIDTH steps go to FIX.
- FIX (normal path):
  - quotient = sign_q ? -Q : Q, and remainder = sign_r ? -R : R, both mod 2^WIDTH.
  - overflow = signed_op AND dividend==0x80 AND divisor==0xFF; the quotient wraps to 0x80 and the remainder is 0.
  - div_by_zero=0.
- FIX, all paths: done=1 for exactly one cycle, busy=0, and the next state is IDLE.
- Latency: with start accepted at edge N, done is high in the cycle after edge N+WIDTH+1, i.e. 9 edges for WIDTH=8. For divide-by-zero, done is high after edge N+1.
- Handshake:
  - start while busy is ignored; operands are not re-latched.
  - start in the done cycle is accepted, since the FSM is already in IDLE; back-to-back throughput is one result per WIDTH+2 cycles.
  - start held high continuously launches a new operation each time IDLE is reached.
- Output hold: quotient, remainder and the flags hold their values until the next FIX write. They are not cleared by start.
- Unsigned mode: no abs/negate and overflow is never set. 0x80/0xFF gives quotient 0 and remainder 0x80.

Decomposition:
- Shared package alu_pkg:
  - state encoding constants ST_IDLE, ST_CALC, ST_FIX;
  - DIV_WIDTH = 8;
  - DIV_ZERO_QUOT = all ones;
  - a two's-complement negate function, shared with the multiplier sign handling.
- One sub-module, div_step: combinational single restoring step. Inputs R, Q, D; outputs next R and next Q.
- FSM, counter and sign fix-up stay in seq_divider.

Test Plan:
- Unsigned 100/7, signed_op=0 -> quotient=14 (0x0E), remainder=2. done pulses exactly 9 edges after start, busy high for 9 cycles.
- Signed -100/7 (0x9C/0x07) -> quotient=0xF2 (-14), remainder=0xFE (-2). Signed 100/-7 -> 0xF2, 0x02.
- Signed 0x80/0xFF -> quotient=0x80, remainder=0x00, overflow=1. Same operands unsigned -> quotient=0x00, remainder=0x80, overflow=0.
- 55/0 (0x37/0x00), either mode -> quotient=0xFF, remainder=0x37, div_by_zero=1. done pulses 1 edge after start.
- Start pulse during CALC with new operands (200/3) -> ignored; the first result completes unchanged. Start asserted in the done cycle -> second op 200/3 unsigned gives 66, remainder 2.
- rst at step 4 of CALC -> next cycle all outputs 0 and state IDLE, with no done pulse. A following start 9/3 -> quotient 3, remainder 0.
